// File: rtl/pcm_to_i2s_pkg.sv
// rtl/pcm_to_i2s_pkg.sv - shared parameters, types and helpers for the I2S transmitter
//
// Purpose : default sample/slot geometry shared with the i2s_to_pcm receiver,
//           the channel encoding carried on ws, and the slot counter width helper.
// Ports   : none (package)

package pcm_to_i2s_pkg;

    // Bits per PCM sample and clk cycles per ws half-period.
    localparam int DEFAULT_NUMBER_OF_BITS = 8;
    localparam int DEFAULT_SLOT_BITS      = 32;

    // ws encoding: left channel is sent while ws is low.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    // Width of a counter that runs 0..slot_bits-1 (at least one bit).
    function automatic int slot_cnt_width(input int slot_bits);
        return (slot_bits > 1) ? $clog2(slot_bits) : 1;
    endfunction

endpackage

// File: rtl/pcm_to_i2s_if.sv
// rtl/pcm_to_i2s_if.sv - PCM sample handshake between a producer and the I2S transmitter
//
// Purpose : one stereo sample per valid/ready transfer.
// Signals : pcm_valid  producer has a sample on pcm_left/pcm_right
//           pcm_ready  transmitter can take the sample this cycle
//           pcm_left   left sample (sent while ws=0)
//           pcm_right  right sample (sent while ws=1)
// Modports: master = producer, slave = transmitter

interface pcm_to_i2s_if
    import pcm_to_i2s_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS
);
    logic                      pcm_valid;
    logic                      pcm_ready;
    logic [NUMBER_OF_BITS-1:0] pcm_left;
    logic [NUMBER_OF_BITS-1:0] pcm_right;

    modport master (
        output pcm_valid,
        output pcm_left,
        output pcm_right,
        input  pcm_ready
    );

    modport slave (
        input  pcm_valid,
        input  pcm_left,
        input  pcm_right,
        output pcm_ready
    );
endinterface

// File: rtl/pcm_to_i2s_ws_gen.sv
// rtl/pcm_to_i2s_ws_gen.sv - word-select generator: slot counter, ws and frame boundary strobe
//
// Purpose : counts SLOT_BITS clk cycles per channel slot and toggles ws on each wrap.
//           Shared with the receiver side so tx and rx agree on ws timing.
// Ports   : clk       bit clock
//           reset     synchronous, active-high; restarts a full left slot
//           slot_cnt  position inside the current slot, 0..SLOT_BITS-1
//           ws        registered word select, 0=left, 1=right
//           boundary  high during the last cycle of the right slot (end of frame)

module pcm_to_i2s_ws_gen
    import pcm_to_i2s_pkg::*;
#(
    parameter int SLOT_BITS = DEFAULT_SLOT_BITS,
    parameter int CNT_W     = slot_cnt_width(SLOT_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             ws,
    output logic             boundary
);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);

    logic slot_wrap;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign boundary  = slot_wrap && ws;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            ws       <= 1'b0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            ws       <= ~ws;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pcm_to_i2s.sv
// rtl/pcm_to_i2s.sv - I2S transmitter: parallel stereo PCM in, ws/sd out
//
// Purpose : one-entry holding register decouples the producer from frame timing;
//           at each frame boundary the held sample moves into the shift registers
//           and is sent MSB first, one clk after each ws edge.
// Ports   : clk          bit clock
//           reset        synchronous, active-high
//           pcm          sample handshake (slave side)
//           ws           registered word select, 0=left, 1=right
//           sd           registered serial data
//           frame_start  1-cycle pulse in the first cycle of the left slot
//           underrun     pulses with frame_start when the frame carries no sample

module pcm_to_i2s
    import pcm_to_i2s_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
    parameter int SLOT_BITS      = DEFAULT_SLOT_BITS
) (
    input  logic          clk,
    input  logic          reset,
    pcm_to_i2s_if.slave   pcm,
    output logic          ws,
    output logic          sd,
    output logic          frame_start,
    output logic          underrun
);

    localparam int CNT_W = slot_cnt_width(SLOT_BITS);
    localparam logic [CNT_W-1:0] DATA_SLOTS = CNT_W'(NUMBER_OF_BITS);

    logic [CNT_W-1:0]          slot_cnt;
    logic                      boundary;
    logic                      accept;
    logic                      bit_slot;
    channel_e                  active_ch;

    logic                      hold_full;
    logic [NUMBER_OF_BITS-1:0] hold_l;
    logic [NUMBER_OF_BITS-1:0] hold_r;
    logic [NUMBER_OF_BITS-1:0] shift_l;
    logic [NUMBER_OF_BITS-1:0] shift_r;

    pcm_to_i2s_ws_gen #(
        .SLOT_BITS (SLOT_BITS),
        .CNT_W     (CNT_W)
    ) u_ws_gen (
        .clk      (clk),
        .reset    (reset),
        .slot_cnt (slot_cnt),
        .ws       (ws),
        .boundary (boundary)
    );

    // At the boundary the holding register is emptied on the same edge, so an
    // empty holding register there lets a new sample bypass straight to the shifters.
    assign pcm.pcm_ready = !reset && !hold_full;
    assign accept        = pcm.pcm_valid && pcm.pcm_ready;

    assign active_ch = channel_e'(ws);

    // sd is registered, so a data bit is launched one cycle ahead: slot_cnt
    // 0..NUMBER_OF_BITS-1 now puts bits on the wire at 1..NUMBER_OF_BITS.
    // SLOT_BITS > NUMBER_OF_BITS keeps this window clear of the slot wrap,
    // so ws is the same in the launch cycle and the display cycle.
    assign bit_slot = (slot_cnt < DATA_SLOTS);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            shift_l     <= '0;
            shift_r     <= '0;
            sd          <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= boundary;
            underrun    <= 1'b0;

            if (boundary) begin
                hold_full <= 1'b0;
                sd        <= 1'b0;
                if (hold_full) begin
                    shift_l <= hold_l;
                    shift_r <= hold_r;
                end else if (accept) begin
                    shift_l <= pcm.pcm_left;
                    shift_r <= pcm.pcm_right;
                end else begin
                    shift_l  <= '0;
                    shift_r  <= '0;
                    underrun <= 1'b1;
                end
            end else begin
                if (accept) begin
                    hold_full <= 1'b1;
                    hold_l    <= pcm.pcm_left;
                    hold_r    <= pcm.pcm_right;
                end

                if (bit_slot) begin
                    if (active_ch == CH_LEFT) begin
                        sd      <= shift_l[NUMBER_OF_BITS-1];
                        shift_l <= shift_l << 1;
                    end else begin
                        sd      <= shift_r[NUMBER_OF_BITS-1];
                        shift_r <= shift_r << 1;
                    end
                end else begin
                    sd <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb/tb_pcm_to_i2s.sv - scoreboard bench for pcm_to_i2s with directed stereo samples

module tb_pcm_to_i2s;

    typedef struct {
        logic [7:0] l;
        logic [7:0] r;
        logic       und;
    } frame_t;

    logic clk;
    logic reset;
    logic ws;
    logic sd;
    logic frame_start;
    logic underrun;

    pcm_to_i2s_if #(.NUMBER_OF_BITS(8)) bus ();

    pcm_to_i2s #(
        .NUMBER_OF_BITS (8),
        .SLOT_BITS      (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcm         (bus.slave),
        .ws          (ws),
        .sd          (sd),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    int     total = 0;
    int     bad   = 0;
    frame_t exp_q[$];

    // Bench-side time base: tcnt is the cycle index since the last reset edge,
    // rst_q says whether the DUT state in this cycle is the reset state.
    int   tcnt  = 0;
    logic rst_q = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rst_q <= reset;
        if (reset) tcnt <= 0;
        else       tcnt <= tcnt + 1;
    end

    task automatic note_fail(input string name, input int act, input int req);
        bad++;
        if (bad <= 30)
            $display("FAIL %s: got %0h, required %0h (t=%0t tcnt=%0d)", name, act, req, $time, tcnt);
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) note_fail(name, int'(act), int'(req));
    endtask

    task automatic chk32(input string name, input int act, input int req);
        total++;
        if (act != req) note_fail(name, act, req);
    endtask

    // Monitor: every cycle compares ws/frame_start/underrun/sd with the frame model,
    // popping the next expected frame whenever a frame must start.
    frame_t     cur;
    logic       in_frame = 1'b0;
    logic       m_ws, m_fs, m_und, m_sd;
    logic [7:0] m_data, m_sh;
    int         m_k;

    always @(negedge clk) begin
        if (reset) chk1("ready_in_reset", bus.pcm_ready, 1'b0);
        if (rst_q) begin
            in_frame = 1'b0;
            chk1("ws_reset", ws, 1'b0);
            chk1("sd_reset", sd, 1'b0);
            chk1("frame_start_reset", frame_start, 1'b0);
            chk1("underrun_reset", underrun, 1'b0);
        end else begin
            m_ws  = ((tcnt % 64) >= 32);
            m_fs  = (tcnt >= 64) && ((tcnt % 64) == 0);
            m_und = 1'b0;
            if (m_fs) begin
                if (exp_q.size() == 0) begin
                    total++;
                    note_fail("frame_without_expectation", 0, 1);
                    in_frame = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    in_frame = 1'b1;
                    m_und    = cur.und;
                end
            end
            m_sd = 1'b0;
            m_k  = tcnt % 32;
            if (in_frame && m_k >= 1 && m_k <= 8) begin
                m_data = m_ws ? cur.r : cur.l;
                m_sh   = m_data >> (8 - m_k);
                m_sd   = m_sh[0];
            end
            chk1("ws", ws, m_ws);
            chk1("frame_start", frame_start, m_fs);
            chk1("underrun", underrun, m_und);
            chk1("sd", sd, m_sd);
        end
    end

    task automatic wait_tcnt(input int n);
        int i;
        i = 0;
        while (tcnt != n && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk32("wait_tcnt", tcnt, n);
    endtask

    // Presents a sample (valid stays high on return) and reports the cycle it was taken in.
    task automatic send(input logic [7:0] l, input logic [7:0] r, input bit push, output int acc_at);
        logic rdy;
        int   cyc;
        bus.pcm_left  = l;
        bus.pcm_right = r;
        bus.pcm_valid = 1'b1;
        acc_at        = -1;
        #1;
        for (int i = 0; i < 300 && acc_at < 0; i++) begin
            rdy = bus.pcm_ready;
            cyc = tcnt;
            @(posedge clk);
            #1;
            if (rdy) acc_at = cyc;
        end
        if (acc_at >= 0 && push) exp_q.push_back('{l: l, r: r, und: 1'b0});
    endtask

    initial begin
        int acc;
        reset         = 1'b1;
        bus.pcm_valid = 1'b1;
        bus.pcm_left  = 8'hA5;
        bus.pcm_right = 8'h3C;

        // 1: three reset clocks with valid high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("t1_ready_during_reset", bus.pcm_ready, 1'b0);
            chk1("t1_ws_during_reset", ws, 1'b0);
            chk1("t1_sd_during_reset", sd, 1'b0);
        end
        reset = 1'b0;

        // 2: the pending sample is taken in the first cycle after reset
        send(8'hA5, 8'h3C, 1'b1, acc);
        bus.pcm_valid = 1'b0;
        chk32("t1_accept_cycle", acc, 0);
        chk1("t2_ready_when_full", bus.pcm_ready, 1'b0);
        wait_tcnt(31);
        chk1("t1_ws_before_rise", ws, 1'b0);
        wait_tcnt(32);
        chk1("t1_ws_rise", ws, 1'b1);

        // 3: valid held high across three samples
        wait_tcnt(70);
        send(8'h11, 8'h22, 1'b1, acc);
        chk32("t3_accept1_cycle", acc, 70);
        send(8'h96, 8'h4B, 1'b1, acc);
        chk32("t3_accept2_cycle", acc, 128);
        send(8'hF0, 8'h0F, 1'b1, acc);
        chk32("t3_accept3_cycle", acc, 192);
        bus.pcm_valid = 1'b0;

        // 4: frame at 320 goes out empty
        exp_q.push_back('{l: 8'h00, r: 8'h00, und: 1'b1});
        wait_tcnt(320);
        chk1("t4_frame_start", frame_start, 1'b1);
        chk1("t4_underrun", underrun, 1'b1);
        wait_tcnt(321);
        chk1("t4_frame_start_pulse", frame_start, 1'b0);
        chk1("t4_underrun_pulse", underrun, 1'b0);

        // 5: bypass, valid first raised at the boundary cycle
        wait_tcnt(383);
        send(8'h81, 8'h7E, 1'b1, acc);
        bus.pcm_valid = 1'b0;
        chk32("t5_accept_at_boundary", acc, 383);
        chk1("t5_no_underrun", underrun, 1'b0);
        chk1("t5_frame_start", frame_start, 1'b1);

        // 6: reset at slot_cnt 5 of the left slot with a sample waiting in holding
        wait_tcnt(386);
        send(8'hC3, 8'h5A, 1'b0, acc);
        bus.pcm_valid = 1'b0;
        chk32("t6_hold_accept", acc, 386);
        wait_tcnt(389);
        reset = 1'b1;
        #1;
        chk1("t6_ready_in_reset", bus.pcm_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("t6_ws_after_reset", ws, 1'b0);
        chk1("t6_sd_after_reset", sd, 1'b0);
        reset = 1'b0;
        exp_q.push_back('{l: 8'h00, r: 8'h00, und: 1'b1});
        #1;
        chk1("t6_holding_empty", bus.pcm_ready, 1'b1);
        wait_tcnt(63);
        chk1("t6_no_early_frame", frame_start, 1'b0);
        wait_tcnt(64);
        chk1("t6_frame_start_64", frame_start, 1'b1);
        chk1("t6_underrun", underrun, 1'b1);
        wait_tcnt(127);
        chk32("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        total++;
        note_fail("watchdog", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
